bus_arb5: RTL

- Round-robin arbiter that shares the 16-bit five-input bus mux (select 3'd0..3'd4 = inputs A..E) between five requesters.
- Issues a one-hot grant and drives the mux select.
- Enforces a maximum hold time when another requester is waiting.
- Inserts a one-cycle idle gap between owners so the bus never switches mid-transfer.

---
 rtl/bus_arb5_pkg.sv | 23 ++
 rtl/bus_arb5_rr_pick5.sv | 32 +++
 rtl/bus_arb5.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bus_arb5_pkg.sv
// Shared constants, FSM state type and helpers for the five-way bus arbiter.
package bus_arb5_pkg;

  localparam int unsigned NREQ  = 5;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Index of the set bit of a one-hot vector; zero when the vector is empty.
  function automatic logic [SEL_W-1:0] onehot_to_sel(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (oh[i]) sel = SEL_W'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/bus_arb5_rr_pick5.sv
// Combinational rotating-priority encoder: first set req bit after ptr, modulo five.
module rr_pick5
  import bus_arb5_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [NREQ-1:0]  w_oh;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // Scan ptr+1 .. ptr+5 so the previous winner is considered last.
  always_comb begin
    w_oh    = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = SEL_W'((32'(ptr) + 32'(k)) % 32'(NREQ));
      if (!w_found && req[w_idx]) begin
        w_oh[w_idx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end

  assign any = |req;
  assign win = onehot_to_sel(w_oh);

endmodule

// File: rtl/bus_arb5.sv
// Round-robin owner arbiter for the 16-bit five-input bus mux, with hold timeout and idle gap.
// Optional BUS_ARB5_LOCK_EN adds a LOCK input that suppresses the timeout release.
module bus_arb5
  import bus_arb5_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
)(
  input  logic             CLK,
  input  logic             RST,
`ifdef BUS_ARB5_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ-1:0]  DONE,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] S,
  output logic             VALID
);

  localparam int unsigned HOLD_W   = 8;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt,   w_gnt_nxt;
  logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
  logic              r_valid, w_valid_nxt;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
  logic [HOLD_W-1:0] r_hold,  w_hold_nxt;

  logic             w_any;
  logic [SEL_W-1:0] w_win;
  logic             w_lock;
  logic             w_others;
  logic             w_timeout;
  logic             w_release;

`ifdef BUS_ARB5_LOCK_EN
  assign w_lock = LOCK;
`else
  assign w_lock = 1'b0;
`endif

  rr_pick5 u_pick (
    .req (REQ),
    .ptr (r_ptr),
    .any (w_any),
    .win (w_win)
  );

  // Release causes for the current owner; several at once still give one release.
  assign w_others  = |(REQ & ~r_gnt);
  assign w_timeout = (r_hold == HOLD_MAX) && w_others && !w_lock;
  assign w_release = DONE[r_sel] || !REQ[r_sel] || w_timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SEL_W'(NREQ - 1);
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = GRANT;
      GRANT:   if (w_release) w_state_nxt = GAP;
      GAP:     w_state_nxt = w_any ? GRANT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      IDLE, GAP: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_sel_nxt   = w_win;
          w_valid_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = r_sel;
          w_hold_nxt  = '0;
        end else if (!w_lock && (r_hold != HOLD_MAX)) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign GNT   = r_gnt;
  assign S     = r_sel;
  assign VALID = r_valid;

endmodule
